// File: rtl/io_ctrl_pkg.sv
// Shared types and constants for the switch/key driven memory access sequencer.
package io_ctrl_pkg;

    localparam int unsigned ADDR_W  = 25;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned SW_W    = 9;
    localparam int unsigned STATE_W = 13;
    localparam int unsigned MODE_W  = 2;

    // Enum values are the bit positions used in the one-hot debug view
    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        READ_ST0   = 4'd1,
        READ_ST1   = 4'd2,
        READ_ST2   = 4'd3,
        READ_WAIT  = 4'd4,
        READ_DONE  = 4'd5,
        WRITE_ST0  = 4'd6,
        WRITE_ST1  = 4'd7,
        WRITE_ST2  = 4'd8,
        WRITE_ST3  = 4'd9,
        WRITE_ST4  = 4'd10,
        WRITE_WAIT = 4'd11,
        WRITE_DONE = 4'd12
    } state_e;

    localparam logic [MODE_W-1:0] MODE_NONE  = 2'b00;
    localparam logic [MODE_W-1:0] MODE_READ  = 2'b01;
    localparam logic [MODE_W-1:0] MODE_WRITE = 2'b10;

    function automatic logic [MODE_W-1:0] mode_for(input state_e s);
        case (s)
            READ_WAIT:  mode_for = MODE_READ;
            WRITE_WAIT: mode_for = MODE_WRITE;
            default:    mode_for = MODE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/in_out_control.sv
// Operator sequencer: collects address/data chunks from switches on key1,
// issues a read or write to the memory controller and shows the result.
module in_out_control
    import io_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                key0_pulse,
    input  logic                key1_pulse,
    input  logic [SW_W-1:0]     sw,
    input  logic                memDone,
    input  logic [DATA_W-1:0]   read_data,
    output logic [MODE_W-1:0]   modeOutput,
    output logic [ADDR_W-1:0]   memoryAddress,
    output logic [DATA_W-1:0]   write_data,
    output logic [DATA_W-1:0]   displayData,
    output logic                ioDone,
    output logic [STATE_W-1:0]  out_state
);

    state_e              state, state_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                first_wait;
    logic                in_wait_c;
    logic                abort_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            memoryAddress <= '0;
            write_data    <= '0;
            rdata_q       <= '0;
            first_wait    <= 1'b0;
            modeOutput    <= MODE_NONE;
            ioDone        <= 1'b0;
            out_state     <= STATE_W'(1);
        end else begin
            state         <= state_d;
            memoryAddress <= addr_d;
            write_data    <= wdata_d;
            rdata_q       <= rdata_d;
            // memDone is not trusted on the first WAIT cycle
            first_wait    <= (state_d == READ_WAIT || state_d == WRITE_WAIT) && !in_wait_c;
            modeOutput    <= mode_for(state_d);
            ioDone        <= (state_d == READ_DONE) || (state_d == WRITE_DONE);
            out_state     <= STATE_W'(1) << state_d;
        end
    end

    // Next-state and chunk-latch decode
    always_comb begin
        state_d   = state;
        addr_d    = memoryAddress;
        wdata_d   = write_data;
        rdata_d   = rdata_q;
        in_wait_c = (state == READ_WAIT) || (state == WRITE_WAIT);
        abort_c   = key0_pulse && key1_pulse && !in_wait_c;

        if (abort_c) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: if (key0_pulse) state_d = sw[8] ? WRITE_ST0 : READ_ST0;
                READ_ST0: if (key1_pulse) begin
                    addr_d[7:0] = sw[7:0];
                    state_d     = READ_ST1;
                end
                READ_ST1: if (key1_pulse) begin
                    addr_d[15:8] = sw[7:0];
                    state_d      = READ_ST2;
                end
                READ_ST2: if (key1_pulse) begin
                    addr_d[24:16] = sw[8:0];
                    state_d       = READ_WAIT;
                end
                READ_WAIT: if (!first_wait && memDone) begin
                    rdata_d = read_data;
                    state_d = READ_DONE;
                end
                READ_DONE: if (key0_pulse) state_d = IDLE;
                WRITE_ST0: if (key1_pulse) begin
                    addr_d[7:0] = sw[7:0];
                    state_d     = WRITE_ST1;
                end
                WRITE_ST1: if (key1_pulse) begin
                    addr_d[15:8] = sw[7:0];
                    state_d      = WRITE_ST2;
                end
                WRITE_ST2: if (key1_pulse) begin
                    addr_d[24:16] = sw[8:0];
                    state_d       = WRITE_ST3;
                end
                WRITE_ST3: if (key1_pulse) begin
                    wdata_d[7:0] = sw[7:0];
                    state_d      = WRITE_ST4;
                end
                WRITE_ST4: if (key1_pulse) begin
                    wdata_d[15:8] = sw[7:0];
                    state_d       = WRITE_WAIT;
                end
                WRITE_WAIT: if (!first_wait && memDone) state_d = WRITE_DONE;
                WRITE_DONE: state_d = IDLE;
                default:    state_d = IDLE;
            endcase
        end
    end

    // Display source follows the registered state; entry states show live switches
    always_comb begin
        displayData = '0;
        case (state)
            READ_ST0, READ_ST1, READ_ST2,
            WRITE_ST0, WRITE_ST1, WRITE_ST2,
            WRITE_ST3, WRITE_ST4:   displayData = DATA_W'(sw);
            WRITE_WAIT, WRITE_DONE: displayData = write_data;
            READ_WAIT, READ_DONE:   displayData = rdata_q;
            default:                displayData = '0;
        endcase
    end

endmodule

// File: tb/tb_in_out_control.sv
// Table-driven bench for in_out_control with a queue of expected post-edge outputs.
module tb_in_out_control;
    import io_ctrl_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                key0_pulse;
    logic                key1_pulse;
    logic [SW_W-1:0]     sw;
    logic                memDone;
    logic [DATA_W-1:0]   read_data;
    logic [MODE_W-1:0]   modeOutput;
    logic [ADDR_W-1:0]   memoryAddress;
    logic [DATA_W-1:0]   write_data;
    logic [DATA_W-1:0]   displayData;
    logic                ioDone;
    logic [STATE_W-1:0]  out_state;

    in_out_control dut (
        .clk           (clk),
        .reset         (reset),
        .key0_pulse    (key0_pulse),
        .key1_pulse    (key1_pulse),
        .sw            (sw),
        .memDone       (memDone),
        .read_data     (read_data),
        .modeOutput    (modeOutput),
        .memoryAddress (memoryAddress),
        .write_data    (write_data),
        .displayData   (displayData),
        .ioDone        (ioDone),
        .out_state     (out_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        k0;
        logic        k1;
        logic [8:0]  sw;
        logic        md;
        logic [15:0] rd;
        logic [12:0] st;
        logic [1:0]  mode;
        logic [24:0] addr;
        logic [15:0] wd;
        logic [15:0] disp;
        logic        done;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    int   step_no = 0;
    vec_t exp_q[$];
    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic k0, input logic k1,
                                input logic [8:0] s, input logic md, input logic [15:0] rd,
                                input int st, input logic [1:0] mode, input logic [24:0] addr,
                                input logic [15:0] wd, input logic [15:0] disp, input logic done);
        vec_t v;
        v.rst  = rst;
        v.k0   = k0;
        v.k1   = k1;
        v.sw   = s;
        v.md   = md;
        v.rd   = rd;
        v.st   = 13'(1) << st;
        v.mode = mode;
        v.addr = addr;
        v.wd   = wd;
        v.disp = disp;
        v.done = done;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL step %0d %s: got %h want %h", step_no, name, got, want);
        end
    endtask

    // Drive one cycle of stimulus and queue what must appear after the edge
    task automatic drive(input vec_t v);
        @(negedge clk);
        reset      = v.rst;
        key0_pulse = v.k0;
        key1_pulse = v.k1;
        sw         = v.sw;
        memDone    = v.md;
        read_data  = v.rd;
        exp_q.push_back(v);
    endtask

    task automatic check_out();
        vec_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL step %0d queue: got empty want entry", step_no);
        end else begin
            e = exp_q.pop_front();
            cmp("out_state",     32'(out_state),     32'(e.st));
            cmp("modeOutput",    32'(modeOutput),    32'(e.mode));
            cmp("memoryAddress", 32'(memoryAddress), 32'(e.addr));
            cmp("write_data",    32'(write_data),    32'(e.wd));
            cmp("displayData",   32'(displayData),   32'(e.disp));
            cmp("ioDone",        32'(ioDone),        32'(e.done));
        end
        step_no++;
    endtask

    task automatic run(input vec_t v);
        drive(v);
        check_out();
    endtask

    initial begin
        reset = 1'b1; key0_pulse = 1'b0; key1_pulse = 1'b0;
        sw = '0; memDone = 1'b1; read_data = '0;

        // Reset state
        run(mk(1,0,0, 9'h000, 1, 16'h0000,  0, 2'b00, 25'h0000000, 16'h0000, 16'h0000, 0));

        //        rst k0 k1 sw     md rd         st mode   addr          wd        disp      done
        // Read flow, key1 ignored in READ_DONE and IDLE
        vecs.push_back(mk(0,1,0, 9'h0FF, 1, 16'h0000,  1, 2'b00, 25'h0000000, 16'h0000, 16'h00FF, 0));
        vecs.push_back(mk(0,0,1, 9'h0FF, 1, 16'h0000,  2, 2'b00, 25'h00000FF, 16'h0000, 16'h00FF, 0));
        vecs.push_back(mk(0,0,1, 9'h0FF, 1, 16'h0000,  3, 2'b00, 25'h000FFFF, 16'h0000, 16'h00FF, 0));
        vecs.push_back(mk(0,0,1, 9'h1FF, 0, 16'h0000,  4, 2'b01, 25'h1FFFFFF, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0,0,0, 9'h000, 0, 16'hAAAA,  4, 2'b01, 25'h1FFFFFF, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0,0,0, 9'h000, 1, 16'hAAAA,  5, 2'b00, 25'h1FFFFFF, 16'h0000, 16'hAAAA, 1));
        vecs.push_back(mk(0,0,1, 9'h055, 1, 16'h0000,  5, 2'b00, 25'h1FFFFFF, 16'h0000, 16'hAAAA, 1));
        vecs.push_back(mk(0,1,0, 9'h000, 1, 16'h0000,  0, 2'b00, 25'h1FFFFFF, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0,0,1, 9'h012, 1, 16'h0000,  0, 2'b00, 25'h1FFFFFF, 16'h0000, 16'h0000, 0));
        // Write flow; sw[8] must be ignored on the data chunks
        vecs.push_back(mk(0,1,0, 9'h100, 1, 16'h0000,  6, 2'b00, 25'h1FFFFFF, 16'h0000, 16'h0100, 0));
        vecs.push_back(mk(0,0,1, 9'h034, 1, 16'h0000,  7, 2'b00, 25'h1FFFF34, 16'h0000, 16'h0034, 0));
        vecs.push_back(mk(0,0,1, 9'h012, 1, 16'h0000,  8, 2'b00, 25'h1FF1234, 16'h0000, 16'h0012, 0));
        vecs.push_back(mk(0,0,1, 9'h1AB, 1, 16'h0000,  9, 2'b00, 25'h1AB1234, 16'h0000, 16'h01AB, 0));
        vecs.push_back(mk(0,0,1, 9'h0CD, 1, 16'h0000, 10, 2'b00, 25'h1AB1234, 16'h00CD, 16'h00CD, 0));
        vecs.push_back(mk(0,0,1, 9'h1AB, 0, 16'h0000, 11, 2'b10, 25'h1AB1234, 16'hABCD, 16'hABCD, 0));
        vecs.push_back(mk(0,0,0, 9'h000, 0, 16'h0000, 11, 2'b10, 25'h1AB1234, 16'hABCD, 16'hABCD, 0));
        vecs.push_back(mk(0,0,0, 9'h000, 1, 16'h0000, 12, 2'b00, 25'h1AB1234, 16'hABCD, 16'hABCD, 1));
        vecs.push_back(mk(0,0,0, 9'h000, 1, 16'h0000,  0, 2'b00, 25'h1AB1234, 16'hABCD, 16'h0000, 0));
        // Abort with both keys in READ_ST1 keeps the entered low byte
        vecs.push_back(mk(0,1,0, 9'h000, 1, 16'h0000,  1, 2'b00, 25'h1AB1234, 16'hABCD, 16'h0000, 0));
        vecs.push_back(mk(0,0,1, 9'h05A, 1, 16'h0000,  2, 2'b00, 25'h1AB125A, 16'hABCD, 16'h005A, 0));
        vecs.push_back(mk(0,1,1, 9'h077, 1, 16'h0000,  0, 2'b00, 25'h1AB125A, 16'hABCD, 16'h0000, 0));
        // memDone already high on WAIT entry; keys ignored while waiting
        vecs.push_back(mk(0,1,0, 9'h000, 1, 16'h0000,  1, 2'b00, 25'h1AB125A, 16'hABCD, 16'h0000, 0));
        vecs.push_back(mk(0,0,1, 9'h001, 1, 16'h0000,  2, 2'b00, 25'h1AB1201, 16'hABCD, 16'h0001, 0));
        vecs.push_back(mk(0,0,1, 9'h002, 1, 16'h0000,  3, 2'b00, 25'h1AB0201, 16'hABCD, 16'h0002, 0));
        vecs.push_back(mk(0,0,1, 9'h003, 1, 16'h1234,  4, 2'b01, 25'h0030201, 16'hABCD, 16'hAAAA, 0));
        vecs.push_back(mk(0,1,1, 9'h000, 1, 16'h1234,  4, 2'b01, 25'h0030201, 16'hABCD, 16'hAAAA, 0));
        vecs.push_back(mk(0,0,0, 9'h000, 1, 16'h1234,  5, 2'b00, 25'h0030201, 16'hABCD, 16'h1234, 1));
        vecs.push_back(mk(0,1,0, 9'h000, 1, 16'h0000,  0, 2'b00, 25'h0030201, 16'hABCD, 16'h0000, 0));

        for (int i = 0; i < vecs.size(); i++) run(vecs[i]);

        // Synchronous reset in the middle of WRITE_WAIT
        run(mk(0,1,0, 9'h100, 0, 16'h0000,  6, 2'b00, 25'h0030201, 16'hABCD, 16'h0100, 0));
        run(mk(0,0,1, 9'h011, 0, 16'h0000,  7, 2'b00, 25'h0030211, 16'hABCD, 16'h0011, 0));
        run(mk(0,0,1, 9'h022, 0, 16'h0000,  8, 2'b00, 25'h0032211, 16'hABCD, 16'h0022, 0));
        run(mk(0,0,1, 9'h000, 0, 16'h0000,  9, 2'b00, 25'h0002211, 16'hABCD, 16'h0000, 0));
        run(mk(0,0,1, 9'h044, 0, 16'h0000, 10, 2'b00, 25'h0002211, 16'hAB44, 16'h0044, 0));
        run(mk(0,0,1, 9'h055, 0, 16'h0000, 11, 2'b10, 25'h0002211, 16'h5544, 16'h5544, 0));
        run(mk(1,0,0, 9'h000, 1, 16'h0000,  0, 2'b00, 25'h0000000, 16'h0000, 16'h0000, 0));
        run(mk(0,0,0, 9'h000, 1, 16'h0000,  0, 2'b00, 25'h0000000, 16'h0000, 16'h0000, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
